// File: rtl/tqvp_bus_arbiter_if.sv
// Requester and peripheral signals of the TinyQV register-bus arbiter.
// master: the arbiter's view. slave: the requesters and peripheral.
interface tqvp_bus_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_rw;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic [1:0]        req0_txn;
   logic              req0_ready;
   logic              req0_done;
   logic [DATA_W-1:0] req0_rdata;

   logic              req1_valid;
   logic              req1_rw;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic [1:0]        req1_txn;
   logic              req1_ready;
   logic              req1_done;
   logic [DATA_W-1:0] req1_rdata;

   logic              timeout;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [1:0]        data_write_n;
   logic [1:0]        data_read_n;
   logic [DATA_W-1:0] data_out;
   logic              data_ready;

   modport master (
      input  req0_valid, req0_rw, req0_addr, req0_wdata, req0_txn,
      output req0_ready, req0_done, req0_rdata,
      input  req1_valid, req1_rw, req1_addr, req1_wdata, req1_txn,
      output req1_ready, req1_done, req1_rdata,
      output timeout, address, data_in, data_write_n, data_read_n,
      input  data_out, data_ready
   );

   modport slave (
      output req0_valid, req0_rw, req0_addr, req0_wdata, req0_txn,
      input  req0_ready, req0_done, req0_rdata,
      output req1_valid, req1_rw, req1_addr, req1_wdata, req1_txn,
      input  req1_ready, req1_done, req1_rdata,
      input  timeout, address, data_in, data_write_n, data_read_n,
      output data_out, data_ready
   );
endinterface

// File: rtl/tqvp_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the TinyQV peripheral bus.
// Serialises accesses, holds read strobes until data_ready and times out stuck reads.
module tqvp_bus_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input logic                clk,
   input logic                rst,
   tqvp_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t            state;
   logic              last_grant;
   logic              cur_id;
   logic [1:0]        cur_txn;
   logic [15:0]       rd_cnt;

   logic              win_id;
   logic              win_rw;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [1:0]        win_raw_txn;
   logic [1:0]        win_txn;
   logic              any_valid;
   logic              rd_finish;
   logic [DATA_W-1:0] rd_result;

   function automatic logic [DATA_W-1:0] mask_rdata(input logic [1:0] txn,
                                                   input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] m;
      m = d;
      if (txn == 2'b00)      m[DATA_W-1:8]  = '0;
      else if (txn == 2'b01) m[DATA_W-1:16] = '0;
      return m;
   endfunction

   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      // Contention goes to whoever was not served last; otherwise the lone requester.
      if (bus.req0_valid && bus.req1_valid) win_id = ~last_grant;
      else                                  win_id = bus.req1_valid;
      if (win_id) begin
         win_rw      = bus.req1_rw;
         win_addr    = bus.req1_addr;
         win_wdata   = bus.req1_wdata;
         win_raw_txn = bus.req1_txn;
      end else begin
         win_rw      = bus.req0_rw;
         win_addr    = bus.req0_addr;
         win_wdata   = bus.req0_wdata;
         win_raw_txn = bus.req0_txn;
      end
      win_txn   = (win_raw_txn == 2'b11) ? 2'b10 : win_raw_txn;
      rd_finish = bus.data_ready || (rd_cnt == 16'(TIMEOUT - 1));
      rd_result = bus.data_ready ? mask_rdata(cur_txn, bus.data_out) : '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         last_grant       <= 1'b1;
         cur_id           <= 1'b0;
         cur_txn          <= 2'b10;
         rd_cnt           <= '0;
         bus.req0_ready   <= 1'b0;
         bus.req0_done    <= 1'b0;
         bus.req0_rdata   <= '0;
         bus.req1_ready   <= 1'b0;
         bus.req1_done    <= 1'b0;
         bus.req1_rdata   <= '0;
         bus.timeout      <= 1'b0;
         bus.address      <= '0;
         bus.data_in      <= '0;
         bus.data_write_n <= 2'b11;
         bus.data_read_n  <= 2'b11;
      end else begin
         bus.req0_ready <= 1'b0;
         bus.req1_ready <= 1'b0;
         bus.req0_done  <= 1'b0;
         bus.req1_done  <= 1'b0;
         bus.timeout    <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  last_grant  <= win_id;
                  cur_id      <= win_id;
                  cur_txn     <= win_txn;
                  bus.address <= win_addr;
                  if (win_id) bus.req1_ready <= 1'b1;
                  else        bus.req0_ready <= 1'b1;
                  // A write completes in its single strobe cycle, so done rides with ready.
                  if (win_rw) begin
                     state            <= WRITE;
                     bus.data_in      <= win_wdata;
                     bus.data_write_n <= win_txn;
                     if (win_id) bus.req1_done <= 1'b1;
                     else        bus.req0_done <= 1'b1;
                  end else begin
                     state           <= READ;
                     bus.data_read_n <= win_txn;
                     rd_cnt          <= '0;
                  end
               end
            end
            WRITE: begin
               state            <= IDLE;
               bus.data_write_n <= 2'b11;
               bus.data_in      <= '0;
            end
            READ: begin
               if (rd_finish) begin
                  state           <= IDLE;
                  bus.data_read_n <= 2'b11;
                  bus.timeout     <= ~bus.data_ready;
                  if (cur_id) begin
                     bus.req1_done  <= 1'b1;
                     bus.req1_rdata <= rd_result;
                  end else begin
                     bus.req0_done  <= 1'b1;
                     bus.req0_rdata <= rd_result;
                  end
               end else begin
                  rd_cnt <= rd_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// Scoreboard bench for tqvp_bus_arbiter: expected completions are queued as requests
// are driven and compared when a done pulse appears; a small peripheral model answers reads.
module tb_tqvp_bus_arbiter;
   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tqvp_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   tqvp_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int unsigned id;
      logic        rw;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [1:0]  txn;
      logic [31:0] rdata;
      logic        tmo;
      int unsigned lat;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;
   logic [31:0] mem [64];
   int unsigned pd_delay = 1;   // strobe cycles until data_ready; 0 = never answer
   int unsigned strobe_cnt = 0;
   logic [1:0]  last_rd_strobe = 2'b11;
   int unsigned rdy_cyc [2];
   logic        prev_wr = 1'b0;
   logic [31:0] hold1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] model_rdata(input logic [1:0] txn, input logic [31:0] d);
      case (txn)
         2'b00:   return {24'h0, d[7:0]};
         2'b01:   return {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   task automatic expect_txn(input int unsigned id, input logic rw, input logic [5:0] addr,
                             input logic [31:0] wdata, input logic [1:0] txn,
                             input int unsigned lat, input logic tmo);
      exp_t e;
      e.id    = id;
      e.rw    = rw;
      e.addr  = addr;
      e.wdata = wdata;
      e.txn   = (txn == 2'b11) ? 2'b10 : txn;
      e.rdata = tmo ? 32'hFFFF_FFFF : model_rdata(e.txn, mem[addr]);
      e.tmo   = tmo;
      e.lat   = lat;
      sb_q.push_back(e);
   endtask

   task automatic drive(input int unsigned id, input logic rw, input logic [5:0] addr,
                        input logic [31:0] wdata, input logic [1:0] txn, input bit keep);
      int unsigned n = 0;
      logic seen = 1'b0;
      if (id == 0) begin
         bus.req0_rw = rw; bus.req0_addr = addr; bus.req0_wdata = wdata;
         bus.req0_txn = txn; bus.req0_valid = 1'b1;
      end else begin
         bus.req1_rw = rw; bus.req1_addr = addr; bus.req1_wdata = wdata;
         bus.req1_txn = txn; bus.req1_valid = 1'b1;
      end
      while (!seen && n < 200) begin
         @(posedge clk); #1;
         n++;
         seen = (id == 0) ? bus.req0_ready : bus.req1_ready;
      end
      check("accept", seen, 1);
      @(posedge clk); #1;
      if (!keep) begin
         if (id == 0) bus.req0_valid = 1'b0;
         else         bus.req1_valid = 1'b0;
      end
   endtask

   task automatic stream(input int unsigned id, input logic [5:0] base);
      for (int unsigned k = 0; k < 4; k++)
         drive(id, 1'b0, base + 6'(k), 32'h0, 2'b10, k != 3);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", sb_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Peripheral: returns mem[address], raises data_ready in strobe cycle pd_delay.
   initial begin
      bus.data_ready = 1'b0;
      bus.data_out   = '0;
      forever begin
         @(posedge clk); #1;
         bus.data_out = mem[bus.address];
         if (bus.data_read_n != 2'b11) begin
            strobe_cnt++;
            last_rd_strobe = bus.data_read_n;
            bus.data_ready = (pd_delay != 0) && (strobe_cnt == pd_delay);
         end else begin
            strobe_cnt     = 0;
            bus.data_ready = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.req0_ready) rdy_cyc[0] = cyc;
      if (bus.req1_ready) rdy_cyc[1] = cyc;
      if (bus.data_write_n != 2'b11) check("wr_single_cycle", prev_wr, 0);
      else                           check("data_in_idle", bus.data_in, 0);
      prev_wr = (bus.data_write_n != 2'b11);
      if (bus.req0_done || bus.req1_done) begin
         int unsigned id;
         exp_t e;
         id = bus.req1_done ? 1 : 0;
         check("done_onehot", bus.req0_done & bus.req1_done, 0);
         check("sb_nonempty", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("done_id", id, e.id);
            check("latency", cyc - rdy_cyc[id], e.lat);
            check("timeout", bus.timeout, e.tmo);
            if (e.rw) begin
               check("wr_strobe", bus.data_write_n, e.txn);
               check("wr_addr", bus.address, e.addr);
               check("wr_data", bus.data_in, e.wdata);
            end else begin
               check("rd_strobe", last_rd_strobe, e.txn);
               check("rd_addr", bus.address, e.addr);
               check("rdata", (id == 0) ? bus.req0_rdata : bus.req1_rdata, e.rdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req0_valid = 1'b0; bus.req0_rw = 1'b0; bus.req0_addr = '0;
      bus.req0_wdata = '0;   bus.req0_txn = 2'b10;
      bus.req1_valid = 1'b0; bus.req1_rw = 1'b0; bus.req1_addr = '0;
      bus.req1_wdata = '0;   bus.req1_txn = 2'b10;
      for (int unsigned i = 0; i < 64; i++) mem[i] = $urandom;
      mem[6'h10] = 32'h1234_5678;
      mem[6'h21] = 32'hCAFE_BABE;

      #1 rst = 1'b1;
      #2;
      check("rst_write_n", bus.data_write_n, 2'b11);
      check("rst_read_n", bus.data_read_n, 2'b11);
      check("rst_address", bus.address, 0);
      check("rst_data_in", bus.data_in, 0);
      check("rst_handshake", {bus.req0_ready, bus.req0_done, bus.req1_ready, bus.req1_done, bus.timeout}, 0);
      check("rst_rdata0", bus.req0_rdata, 0);
      check("rst_rdata1", bus.req1_rdata, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // word write from requester 0
      expect_txn(0, 1'b1, 6'h05, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);
      drive(0, 1'b1, 6'h05, 32'hDEAD_BEEF, 2'b10, 0);
      drain();

      // byte read from requester 1, peripheral answers in the third strobe cycle
      pd_delay = 3;
      expect_txn(1, 1'b0, 6'h10, 32'h0, 2'b00, 3, 1'b0);
      drive(1, 1'b0, 6'h10, 32'h0, 2'b00, 0);
      drain();

      // both requesters streaming reads: grants alternate starting with 0
      pd_delay = 1;
      for (int unsigned k = 0; k < 4; k++) begin
         expect_txn(0, 1'b0, 6'h20 + 6'(k), 32'h0, 2'b10, 1, 1'b0);
         expect_txn(1, 1'b0, 6'h30 + 6'(k), 32'h0, 2'b10, 1, 1'b0);
      end
      fork
         stream(0, 6'h20);
         stream(1, 6'h30);
      join
      drain();
      hold1 = mem[6'h33];

      // read that never completes, then a normal half read
      pd_delay = 0;
      expect_txn(0, 1'b0, 6'h07, 32'h0, 2'b10, TIMEOUT, 1'b1);
      drive(0, 1'b0, 6'h07, 32'h0, 2'b10, 0);
      drain();
      check("rdata1_hold", bus.req1_rdata, hold1);
      pd_delay = 1;
      expect_txn(0, 1'b0, 6'h08, 32'h0, 2'b01, 1, 1'b0);
      drive(0, 1'b0, 6'h08, 32'h0, 2'b01, 0);
      drain();

      // reset in the middle of a read strobe
      pd_delay = 0;
      drive(0, 1'b0, 6'h09, 32'h0, 2'b10, 0);
      for (int unsigned k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("rst_mid_read_n", bus.data_read_n, 2'b11);
      check("rst_mid_done", {bus.req0_done, bus.req1_done}, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      pd_delay = 1;
      expect_txn(0, 1'b1, 6'h0A, 32'h0BAD_F00D, 2'b00, 0, 1'b0);
      expect_txn(1, 1'b1, 6'h0B, 32'h1357_9BDF, 2'b01, 0, 1'b0);
      fork
         drive(0, 1'b1, 6'h0A, 32'h0BAD_F00D, 2'b00, 0);
         drive(1, 1'b1, 6'h0B, 32'h1357_9BDF, 2'b01, 0);
      join
      drain();

      // half read masking and illegal-width write
      expect_txn(1, 1'b0, 6'h21, 32'h0, 2'b01, 1, 1'b0);
      drive(1, 1'b0, 6'h21, 32'h0, 2'b01, 0);
      drain();
      expect_txn(0, 1'b1, 6'h22, 32'h55AA_33CC, 2'b11, 0, 1'b0);
      drive(0, 1'b1, 6'h22, 32'h55AA_33CC, 2'b11, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
